if_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core, directly upstream of the decode stage. Owns the program counter and issues one instruction-memory request at a time over a request/grant/response handshake. Presents each fetched instruction and its PC in a registered IF/ID slot, which feeds decode's instruction and current-PC inputs. Honours pipeline stalls through a one-entry hold buffer and flushes on branch/jump redirects.

---
 rtl/if_stage.sv | 144 ++++++++++++++
 tb/tb_if_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time, and presents a registered IF/ID slot.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect targets raise a one-cycle o_trap pulse.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_instruct,
    output logic [31:0] o_pc,
    output logic        o_trap
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HOLD} state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic        req_fire;
    logic        outstanding;

    // Requests are gated by rst so nothing is issued while reset is held.
    assign o_imem_req  = rst && (state_q == S_REQ) && !(valid_q && i_stall);
    assign o_imem_addr = pc_q;
    assign req_fire    = o_imem_req && i_imem_gnt;
    assign o_valid     = valid_q;
    assign o_instruct  = instr_q;
    assign o_pc        = opc_q;

    // A response is still owed by memory if we are waiting without rvalid or just got a grant.
    assign outstanding = ((state_q == S_WAIT || state_q == S_DRAIN) && !i_imem_rvalid)
                         || req_fire;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        opc_d        = opc_q;

        if (valid_q && !i_stall) valid_d = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    if (!valid_q || !i_stall) begin
                        instr_d = i_imem_rdata;
                        opc_d   = req_pc_q;
                        valid_d = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        hold_instr_d = i_imem_rdata;
                        hold_pc_d    = req_pc_q;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!i_stall) begin
                    instr_d = hold_instr_q;
                    opc_d   = hold_pc_q;
                    valid_d = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (i_imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // Redirect overrides everything above, including stall and a same-cycle response.
        if (i_redirect) begin
            pc_d         = i_redirect_pc & ~32'h3;
            valid_d      = 1'b0;
            instr_d      = instr_q;
            opc_d        = opc_q;
            hold_instr_d = '0;
            hold_pc_d    = '0;
            state_d      = outstanding ? S_DRAIN : S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            valid_q      <= 1'b0;
            instr_q      <= NOP;
            opc_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            opc_q        <= opc_d;
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) trap_q <= 1'b0;
        else      trap_q <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
    end

    assign o_trap = trap_q;
`else
    assign o_trap = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table for the fetch corner cases, then random traffic against a fetch-stream model.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef IF_MISALIGN_TRAP_EN
    localparam logic TRAP_ON = 1'b1;
`else
    localparam logic TRAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        stall, redirect;
    logic [31:0] rpc;
    logic        o_valid;
    logic [31:0] o_instruct, o_pc;
    logic        o_trap;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_gnt   (gnt),
        .i_imem_rvalid(rvalid),
        .i_imem_rdata (rdata),
        .i_stall      (stall),
        .i_redirect   (redirect),
        .i_redirect_pc(rpc),
        .o_valid      (o_valid),
        .o_instruct   (o_instruct),
        .o_pc         (o_pc),
        .o_trap       (o_trap)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: every word is a distinct function of its address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rd_addr;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_trap;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] ra,
                                input logic st, input logic rd, input logic [31:0] rp,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic et);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rd_addr = ra; v.stall = st; v.redir = rd; v.rpc = rp;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_trap = et;
        return v;
    endfunction

    vec_t tbl[$];

    logic [31:0] m_fetch, m_del, m_raddr;
    logic        m_out, m_trap, prev_redir;
    int          m_cnt;
    int          delivered;

    task automatic do_reset();
        rst = 1'b0; gnt = 0; rvalid = 0; rdata = '0; stall = 0; redirect = 0; rpc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, o_imem_req}, 0);
        chk("rst_valid", {31'b0, o_valid}, 0);
        chk("rst_instr", o_instruct, 32'h0000_0013);
        chk("rst_pc", o_pc, 0);
        chk("rst_trap", {31'b0, o_trap}, 0);
        chk("rst_addr", o_imem_addr, RST_PC);
        rst = 1'b1;
    endtask

    initial begin
        //          gnt rv rd_addr       st rd rpc            req addr          vld pc            trap
        tbl.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h100,      0, 0,            0));
        tbl.push_back(mk(0, 1, 32'h100,       0, 0, 0,             0, 0,            0, 0,            0));
        tbl.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h104,      1, 32'h100,      0));
        tbl.push_back(mk(0, 1, 32'h104,       0, 0, 0,             0, 0,            0, 0,            0));
        tbl.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h108,      1, 32'h104,      0));
        tbl.push_back(mk(0, 1, 32'h108,       0, 0, 0,             0, 0,            0, 0,            0));
        tbl.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h10C,      1, 32'h108,      0));
        tbl.push_back(mk(0, 0, 0,             1, 0, 0,             0, 0,            0, 0,            0));
        tbl.push_back(mk(0, 1, 32'h10C,       1, 0, 0,             0, 0,            0, 0,            0));
        tbl.push_back(mk(0, 0, 0,             1, 0, 0,             0, 0,            1, 32'h10C,      0));
        tbl.push_back(mk(0, 0, 0,             1, 0, 0,             0, 0,            1, 32'h10C,      0));
        tbl.push_back(mk(0, 0, 0,             1, 0, 0,             0, 0,            1, 32'h10C,      0));
        tbl.push_back(mk(0, 0, 0,             0, 0, 0,             1, 32'h110,      1, 32'h10C,      0));
        tbl.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h110,      0, 0,            0));
        tbl.push_back(mk(0, 0, 0,             0, 1, 32'h200,       0, 0,            0, 0,            0));
        tbl.push_back(mk(0, 0, 0,             0, 0, 0,             0, 0,            0, 0,            0));
        tbl.push_back(mk(0, 1, 32'h110,       0, 0, 0,             0, 0,            0, 0,            0));
        tbl.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h200,      0, 0,            0));
        tbl.push_back(mk(0, 1, 32'h200,       0, 1, 32'h400,       0, 0,            0, 0,            0));
        tbl.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h400,      0, 0,            0));
        tbl.push_back(mk(0, 1, 32'h400,       0, 0, 0,             0, 0,            0, 0,            0));
        tbl.push_back(mk(0, 0, 0,             0, 1, 32'hFFFF_FFFC, 1, 32'h404,      1, 32'h400,      0));
        tbl.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'hFFFF_FFFC, 0, 0,           0));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0,             0, 0,            0, 0,            0));
        tbl.push_back(mk(0, 0, 0,             0, 1, 32'h302,       1, 32'h0,        1, 32'hFFFF_FFFC, 0));
        tbl.push_back(mk(1, 0, 0,             0, 0, 0,             1, 32'h300,      0, 0,            TRAP_ON));
        tbl.push_back(mk(0, 1, 32'h300,       0, 0, 0,             0, 0,            0, 0,            0));
        tbl.push_back(mk(0, 0, 0,             0, 0, 0,             1, 32'h304,      1, 32'h300,      0));

        do_reset();
        for (int unsigned i = 0; i < tbl.size(); i++) begin
            gnt      = tbl[i].gnt;
            rvalid   = tbl[i].rv;
            rdata    = tbl[i].rv ? memw(tbl[i].rd_addr) : 32'hDEAD_BEEF;
            stall    = tbl[i].stall;
            redirect = tbl[i].redir;
            rpc      = tbl[i].rpc;
            #1;
            chk($sformatf("t%0d_req", i), {31'b0, o_imem_req}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), o_imem_addr, tbl[i].e_addr);
            chk($sformatf("t%0d_valid", i), {31'b0, o_valid}, {31'b0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("t%0d_pc", i), o_pc, tbl[i].e_pc);
                chk($sformatf("t%0d_instr", i), o_instruct, memw(tbl[i].e_pc));
            end
            chk($sformatf("t%0d_trap", i), {31'b0, o_trap}, {31'b0, tbl[i].e_trap});
            @(posedge clk);
            #1;
        end

        // Random traffic: the delivered stream must be consecutive words from the last redirect target.
        do_reset();
        m_fetch = RST_PC; m_del = RST_PC; m_out = 0; m_cnt = 0; m_raddr = '0;
        m_trap = 0; prev_redir = 0; delivered = 0;
        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            stall    = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 11) == 0);
            rpc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                   : ($urandom & 32'h0000_0FFF);
            rvalid   = m_out && (m_cnt == 0);
            rdata    = rvalid ? memw(m_raddr) : $urandom;
            gnt      = 1'b0;
            #1;
            gnt = o_imem_req && ($urandom_range(0, 2) != 0);
            #1;
            if (o_imem_req) begin
                chk("one_outstanding", {31'b0, m_out}, 0);
                chk("fetch_addr", o_imem_addr, m_fetch);
            end
            chk("trap", {31'b0, o_trap}, {31'b0, m_trap});
            if (prev_redir) chk("flush_valid", {31'b0, o_valid}, 0);
            if (o_valid) begin
                chk("slot_pc", o_pc, m_del);
                chk("slot_instr", o_instruct, memw(o_pc));
            end

            if (redirect) m_del = rpc & ~32'h3;
            else if (o_valid && !stall) begin
                m_del = m_del + 32'd4;
                delivered++;
            end
            if (redirect) m_fetch = rpc & ~32'h3;
            else if (o_imem_req && gnt) m_fetch = m_fetch + 32'd4;
            m_trap = TRAP_ON && redirect && (rpc[1:0] != 2'b00);
            if (rvalid) m_out = 0;
            else if (m_out) m_cnt--;
            if (o_imem_req && gnt) begin
                m_out   = 1;
                m_raddr = o_imem_addr;
                m_cnt   = $urandom_range(0, 2);
            end
            prev_redir = redirect;
            @(posedge clk);
            #1;
        end
        chk("progress", {31'b0, (delivered > 100)}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
